tcp_open_conn_sched: RTL and testbench
======================================

TCP_OPEN_CONN_SCHED -- requirements
Module: tcp_open_conn_sched

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of open-connection requesters; TIME_OUT_CYCLE, default 32'h9502_F900, the WAIT-state timeout in clk cycles.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-003 clk  in  1  the only clock.
REQ-004 rst_n  in  1  asynchronous reset, active low.
REQ-005 s_req_valid  in  NUM_REQ  per-requester open request valid.
REQ-006 s_req_ready  out  NUM_REQ  per-requester request accept.
REQ-007 s_req_data  in  NUM_REQ x 48  per requester {port[47:32], ip[31:0]}.
REQ-008 m_open_valid / m_open_ready / m_open_data  out / in / out  1 / 1 / 48  open-connection command to the TCP stack.
REQ-009 s_status_valid / s_status_ready / s_status_data  in / out / in  1 / 1 / 24  open status from the stack: [16] success, [15:0] session id.
REQ-010 m_rsp_valid  out  NUM_REQ  per-requester response valid.
REQ-011 m_rsp_ready  in  NUM_REQ  per-requester response accept.
REQ-012 m_rsp_data  out  18  shared response bus {timeout, success, session[15:0]}.
REQ-013 busy  out  1  high in every state other than IDLE.
REQ-014 timeout_cnt / drop_cnt  out  16 each  saturating event counters.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with exactly one open request outstanding at any time.
REQ-016 IDLE: if any s_req_valid is high, the block SHALL pick grant g round-robin, searching upward from last_grant+1 modulo NUM_REQ.
- In the same cycle it SHALL drive s_req_ready[g] high combinationally, with all other ready bits low.
- It SHALL latch s_req_data[g] and g, then move to ISSUE.
REQ-017 In every state except IDLE, s_req_ready SHALL be all zero.
REQ-018 ISSUE: m_open_valid SHALL be 1 and m_open_data SHALL be the latched data, held stable until ready.
- m_open_valid SHALL rise exactly one cycle after request acceptance.
- On m_open_valid & m_open_ready the block SHALL clear the timer and move to WAIT.
- No timeout SHALL apply in ISSUE.
REQ-019 WAIT: the 32-bit timer SHALL increment every cycle.
- On s_status_valid, the block SHALL latch rsp = {1'b0, s_status_data[16:0]} and move to RESP.
- Otherwise, when timer == TIME_OUT_CYCLE, it SHALL latch rsp = {1'b1, 1'b0, 16'h0}, increment timeout_cnt and move to RESP.
REQ-020 If a status and the timeout occur in the same cycle, the status SHALL take priority and timeout_cnt SHALL NOT increment.
REQ-021 s_status_ready SHALL be constant 1; a status arriving in any state other than WAIT (for example a late reply after a timeout) SHALL be discarded and SHALL increment drop_cnt.
REQ-022 RESP: only m_rsp_valid[g] SHALL be high, and m_rsp_data SHALL equal the latched rsp.
- On m_rsp_ready[g] the block SHALL set last_grant = g and return to IDLE.
- A new grant SHALL be possible on the first IDLE cycle.
REQ-023 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 A requester that drops s_req_valid before it is granted SHALL simply be skipped; no request SHALL be latched from a deasserted valid.

Reset
REQ-025 While rst_n is low, the block SHALL force the following regardless of clk:
- state = IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first);
- timer, timeout_cnt and drop_cnt = 0;
- m_open_valid = 0, m_rsp_valid = 0, s_req_ready = 0, m_open_data = 0, m_rsp_data = 0, busy = 0.
REQ-026 A reset asserted mid-operation SHALL abandon the outstanding request without any response; a stack status arriving after reset release SHALL count as a drop.

Verification
REQ-027 Single request: req1 = {16'd5001, 32'h0A00_0002}, stack ready, status 24'h01_0007 after 10 cycles.
- m_open_valid SHALL be high one cycle after acceptance.
- m_rsp_valid[1] SHALL be high with data 18'h1_0007.
- busy SHALL be 0 after m_rsp_ready.
REQ-028 Round-robin: all four requesters held valid continuously with immediate replies -> grant order SHALL be 0, 1, 2, 3, 0.
REQ-029 Timeout: with TIME_OUT_CYCLE = 100 and no status -> m_rsp_data SHALL be 18'h2_0000 exactly 100 cycles after m_open accept, and timeout_cnt SHALL be 1.
- A status sent afterwards SHALL give drop_cnt = 1 and no m_rsp_valid.
REQ-030 Simultaneous events: status on the same cycle that timer == TIME_OUT_CYCLE -> the response SHALL report success, and timeout_cnt SHALL be unchanged.
REQ-031 Backpressure and reset: with m_open_ready held low for 500 cycles and TIME_OUT_CYCLE = 100 -> no timeout SHALL fire and the data SHALL stay stable.
- Then assert rst_n low in WAIT -> all outputs SHALL be 0 and the next grant SHALL go to requester 0.

Source files
------------

// File: rtl/tcp_open_conn_sched.sv
// Serialises open-connection requests from NUM_REQ requesters onto one TCP stack
// port; one request is outstanding at a time and a WAIT timeout turns it into an error reply.
module tcp_open_conn_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [31:0] TIME_OUT_CYCLE = 32'h9502_F900
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       s_req_valid,
  output logic [NUM_REQ-1:0]       s_req_ready,
  input  logic [NUM_REQ-1:0][47:0] s_req_data,
  output logic                     m_open_valid,
  input  logic                     m_open_ready,
  output logic [47:0]              m_open_data,
  input  logic                     s_status_valid,
  output logic                     s_status_ready,
  input  logic [23:0]              s_status_data,
  output logic [NUM_REQ-1:0]       m_rsp_valid,
  input  logic [NUM_REQ-1:0]       m_rsp_ready,
  output logic [17:0]              m_rsp_data,
  output logic                     busy,
  output logic [15:0]              timeout_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = GW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [47:0]     data_q, data_d;
  logic [17:0]     rsp_q, rsp_d;
  logic [31:0]     timer_q, timer_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [15:0]     dcnt_q, dcnt_d;
  logic [31:0]     timer_inc;
  logic [SW-1:0]   rr_sum;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;
  logic            unused_status_bits;

  assign unused_status_bits = ^s_status_data[23:17];

  // Scan offsets from the top down so the smallest offset after last_grant wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_sum = {1'b0, last_grant_q} + SW'(i);
      if (rr_sum >= SW'(NUM_REQ)) rr_sum = rr_sum - SW'(NUM_REQ);
      if (s_req_valid[rr_sum[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rr_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    rsp_d        = rsp_q;
    timer_d      = timer_q;
    tcnt_d       = tcnt_q;
    dcnt_d       = dcnt_q;
    s_req_ready  = '0;
    m_open_valid = 1'b0;
    timer_inc    = timer_q + 32'd1;

    if (s_status_valid && (state_q != ST_WAIT) && (dcnt_q != 16'hFFFF))
      dcnt_d = dcnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          s_req_ready[pick_idx] = 1'b1;
          grant_d = pick_idx;
          data_d  = s_req_data[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_open_valid = 1'b1;
        if (m_open_ready) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        // A status landing on the timeout cycle still wins.
        if (s_status_valid) begin
          rsp_d   = {1'b0, s_status_data[16:0]};
          state_d = ST_RESP;
        end else if (timer_inc == TIME_OUT_CYCLE) begin
          rsp_d   = {2'b10, 16'h0000};
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      data_q       <= '0;
      rsp_q        <= '0;
      timer_q      <= '0;
      tcnt_q       <= '0;
      dcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      rsp_q        <= rsp_d;
      timer_q      <= timer_d;
      tcnt_q       <= tcnt_d;
      dcnt_q       <= dcnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
    assign m_rsp_valid[gi] = (state_q == ST_RESP) && (grant_q == GW'(gi));
  end

  assign s_status_ready = 1'b1;
  assign busy           = (state_q != ST_IDLE);
  assign m_open_data    = data_q;
  assign m_rsp_data     = rsp_q;
  assign timeout_cnt    = tcnt_q;
  assign drop_cnt       = dcnt_q;

endmodule

// File: tb/tb_tcp_open_conn_sched.sv
// Directed bench for tcp_open_conn_sched: expected opens/responses are queued by the
// stimulus and popped by a monitor when the DUT hands them over.
module tb_tcp_open_conn_sched;

  localparam int NR = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       s_req_valid;
  logic [NR-1:0]       s_req_ready;
  logic [NR-1:0][47:0] s_req_data;
  logic                m_open_valid;
  logic                m_open_ready;
  logic [47:0]         m_open_data;
  logic                s_status_valid;
  logic                s_status_ready;
  logic [23:0]         s_status_data;
  logic [NR-1:0]       m_rsp_valid;
  logic [NR-1:0]       m_rsp_ready;
  logic [17:0]         m_rsp_data;
  logic                busy;
  logic [15:0]         timeout_cnt;
  logic [15:0]         drop_cnt;

  always #5 clk = ~clk;

  tcp_open_conn_sched #(.NUM_REQ(NR), .TIME_OUT_CYCLE(32'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .m_open_valid(m_open_valid), .m_open_ready(m_open_ready), .m_open_data(m_open_data),
    .s_status_valid(s_status_valid), .s_status_ready(s_status_ready), .s_status_data(s_status_data),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .busy(busy), .timeout_cnt(timeout_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [NR-1:0] v;
    logic [17:0]   d;
  } rsp_t;

  rsp_t        rsp_exp_q[$];
  logic [47:0] open_exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns on the first cycle after the open handshake edge (state WAIT, timer 0).
  task automatic wait_open();
    int k = 0;
    while (!(m_open_valid && m_open_ready) && k < 1000) begin
      tick();
      k++;
    end
    check("open_handshake_seen", {63'd0, m_open_valid && m_open_ready}, 64'd1);
    tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_status(input logic [23:0] d);
    s_status_valid = 1'b1;
    s_status_data  = d;
    tick();
    s_status_valid = 1'b0;
  endtask

  task automatic push_txn(input int g, input logic [17:0] d);
    rsp_t e;
    open_exp_q.push_back(s_req_data[g]);
    e.v = NR'(1) << g;
    e.d = d;
    rsp_exp_q.push_back(e);
  endtask

  // Monitor: one line per handed-over open command or response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_open_valid && m_open_ready) begin
        if (open_exp_q.size() == 0) begin
          check("open_unexpected", 64'(m_open_data), 64'hDEAD_0000_0000_0000);
        end else begin
          logic [47:0] eo;
          eo = open_exp_q.pop_front();
          $display("open  data=%h expected=%h", m_open_data, eo);
          check("open_data", 64'(m_open_data), 64'(eo));
        end
      end
      if ((m_rsp_valid & m_rsp_ready) != '0) begin
        if (rsp_exp_q.size() == 0) begin
          check("rsp_unexpected", 64'({m_rsp_valid, m_rsp_data}), 64'hDEAD_0000_0000_0000);
        end else begin
          rsp_t er;
          er = rsp_exp_q.pop_front();
          $display("rsp   valid=%b data=%h expected valid=%b data=%h", m_rsp_valid, m_rsp_data, er.v, er.d);
          check("rsp_valid_data", 64'({m_rsp_valid, m_rsp_data}), 64'(er));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    rst_n          = 1'b0;
    s_req_valid    = '0;
    m_open_ready   = 1'b0;
    s_status_valid = 1'b0;
    s_status_data  = '0;
    m_rsp_ready    = '1;
    for (int i = 0; i < NR; i++) s_req_data[i] = {16'(1000 + i), 32'hC0A8_0000 + 32'(i)};
    s_req_data[1] = {16'd5001, 32'h0A00_0002};

    // Reset state
    tick(3);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_outputs", 64'({m_open_valid, m_rsp_valid, s_req_ready}), 64'd0);
    check("rst_counters", 64'({timeout_cnt, drop_cnt}), 64'd0);
    check("status_ready", {63'd0, s_status_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Single request from requester 1, status after 10 cycles
    push_txn(1, 18'h1_0007);
    m_open_ready = 1'b1;
    s_req_valid  = 4'b0010;
    #1;
    check("idle_ready_onehot", 64'(s_req_ready), 64'h2);
    tick();
    s_req_valid = '0;
    check("open_valid_latency", {63'd0, m_open_valid}, 64'd1);
    check("ready_low_in_issue", 64'(s_req_ready), 64'd0);
    wait_open();
    tick(9);
    pulse_status(24'h01_0007);
    tick();
    check("busy_after_rsp", {63'd0, busy}, 64'd0);

    // Round-robin from reset: 0,1,2,3,0 with immediate replies
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    push_txn(0, 18'h1_0010);
    push_txn(1, 18'h0_0033);
    push_txn(2, 18'h0_1234);
    push_txn(3, 18'h1_FFFF);
    push_txn(0, 18'h1_0042);
    s_req_valid = 4'hF;
    wait_open(); pulse_status(24'h01_0010);
    wait_open(); pulse_status(24'h00_0033);
    wait_open(); pulse_status(24'hFE_1234);
    wait_open(); pulse_status(24'h01_FFFF);
    wait_open(); pulse_status(24'h01_0042);
    s_req_valid = '0;
    wait_idle();

    // Timeout after exactly 100 cycles, then a late status is dropped
    push_txn(2, 18'h2_0000);
    s_req_valid = 4'b0100;
    wait_open();
    s_req_valid = '0;
    n = 0;
    while (m_rsp_valid == '0 && n < 300) begin
      tick();
      n++;
    end
    check("timeout_latency", 64'(n), 64'd100);
    check("timeout_cnt_1", 64'(timeout_cnt), 64'd1);
    tick();
    pulse_status(24'h01_0099);
    check("late_status_drop", 64'(drop_cnt), 64'd1);
    check("late_status_no_rsp", 64'({m_rsp_valid, busy}), 64'd0);
    tick(2);

    // Status on the timeout cycle wins
    push_txn(3, 18'h1_00AB);
    s_req_valid = 4'b1000;
    wait_open();
    s_req_valid = '0;
    tick(99);
    pulse_status(24'h01_00AB);
    check("simul_timeout_cnt", 64'(timeout_cnt), 64'd1);
    check("simul_drop_cnt", 64'(drop_cnt), 64'd1);
    wait_idle();

    // Open backpressure for 500 cycles: no timeout, stable data, other requests held off
    m_open_ready = 1'b0;
    open_exp_q.push_back(s_req_data[0]);
    s_req_valid = 4'b0001;
    tick();
    s_req_valid = '0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 100) s_req_valid = 4'b0100;
      if (i == 200) s_req_valid = '0;
      if (!(m_open_valid && busy && m_open_data == s_req_data[0] && timeout_cnt == 16'd1 && s_req_ready == '0))
        bad++;
      tick();
    end
    check("backpressure_stable", 64'(bad), 64'd0);
    m_open_ready = 1'b1;
    wait_open();
    tick(3);
    rst_n = 1'b0;
    #1;
    check("async_rst_valids", 64'({m_open_valid, m_rsp_valid, s_req_ready, busy}), 64'd0);
    check("async_rst_data", 64'({m_open_data, m_rsp_data}), 64'd0);
    check("async_rst_counters", 64'({timeout_cnt, drop_cnt}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_status(24'h01_0001);
    check("post_rst_drop", 64'(drop_cnt), 64'd1);
    check("post_rst_no_rsp", 64'(m_rsp_valid), 64'd0);
    push_txn(0, 18'h1_0555);
    s_req_valid = 4'b0101;
    wait_open();
    s_req_valid = '0;
    pulse_status(24'h01_0555);
    wait_idle();

    tick(3);
    check("rsp_queue_drained", 64'(rsp_exp_q.size()), 64'd0);
    check("open_queue_drained", 64'(open_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
